// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ID/EX ALU control block: ALUOp values, R-type
// funct values, ALU operation codes and the MULT/DIV sequencer states.
package alu_ctrl_pkg;

  localparam logic [2:0] ALUOP_LUI  = 3'b001;
  localparam logic [2:0] ALUOP_LW   = 3'b010;
  localparam logic [2:0] ALUOP_ANDI = 3'b011;
  localparam logic [2:0] ALUOP_BEQ  = 3'b100;
  localparam logic [2:0] ALUOP_ORI  = 3'b101;
  localparam logic [2:0] ALUOP_ADDI = 3'b110;
  localparam logic [2:0] ALUOP_R    = 3'b111;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_JR   = 6'b001000;
  localparam logic [5:0] FUNCT_MULT = 6'b011000;
  localparam logic [5:0] FUNCT_DIV  = 6'b011010;
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100001;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;

  localparam logic [3:0] OPER_AND  = 4'b0000;
  localparam logic [3:0] OPER_OR   = 4'b0001;
  localparam logic [3:0] OPER_LUI  = 4'b0010;
  localparam logic [3:0] OPER_ADD  = 4'b0011;
  localparam logic [3:0] OPER_SLL  = 4'b0100;
  localparam logic [3:0] OPER_NOR  = 4'b0101;
  localparam logic [3:0] OPER_SRL  = 4'b0110;
  localparam logic [3:0] OPER_SUB  = 4'b0111;
  localparam logic [3:0] OPER_JR   = 4'b1000;
  localparam logic [3:0] OPER_ILL  = 4'b1001;
  localparam logic [3:0] OPER_SLT  = 4'b1010;
  localparam logic [3:0] OPER_MULT = 4'b1011;
  localparam logic [3:0] OPER_DIV  = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/alu_control_pipe_decode.sv
// Purely combinational {ALUOp, funct} -> ALU operation decoder.
module alu_decode
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 3,
  parameter int FUNCT_W = 6,
  parameter int OPER_W  = 4
) (
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic [OPER_W-1:0]  oper,
  output logic               jr,
  output logic               illegal,
  output logic               is_muldiv
);

  // Zero-extended copies let the upper-bit checks work for any width >= the
  // decoded field, including the exact-width case.
  logic [ALUOP_W+2:0] op_ext;
  logic [FUNCT_W+5:0] fn_ext;
  logic               op_hi_zero;
  logic               fn_hi_zero;
  logic [3:0]         code;

  assign op_ext     = {3'b000, alu_op};
  assign fn_ext     = {6'b000000, funct};
  assign op_hi_zero = (op_ext[ALUOP_W+2:3] == '0);
  assign fn_hi_zero = (fn_ext[FUNCT_W+5:6] == '0);

  // Table lookup; anything not listed falls through to the illegal code.
  always_comb begin
    code = OPER_ILL;
    if (op_hi_zero) begin
      case (op_ext[2:0])
        ALUOP_R: begin
          if (fn_hi_zero) begin
            case (fn_ext[5:0])
              FUNCT_AND:  code = OPER_AND;
              FUNCT_OR:   code = OPER_OR;
              FUNCT_ADD:  code = OPER_ADD;
              FUNCT_SUB:  code = OPER_SUB;
              FUNCT_NOR:  code = OPER_NOR;
              FUNCT_SLL:  code = OPER_SLL;
              FUNCT_SRL:  code = OPER_SRL;
              FUNCT_JR:   code = OPER_JR;
              FUNCT_SLT:  code = OPER_SLT;
              FUNCT_MULT: code = OPER_MULT;
              FUNCT_DIV:  code = OPER_DIV;
              default:    code = OPER_ILL;
            endcase
          end
        end
        ALUOP_ADDI: code = OPER_ADD;
        ALUOP_ORI:  code = OPER_OR;
        ALUOP_ANDI: code = OPER_AND;
        ALUOP_LUI:  code = OPER_LUI;
        ALUOP_LW:   code = OPER_ADD;
        ALUOP_BEQ:  code = OPER_SUB;
        default:    code = OPER_ILL;
      endcase
    end
  end

  assign oper      = OPER_W'(code);
  assign jr        = (code == OPER_JR);
  assign illegal   = (code == OPER_ILL);
  assign is_muldiv = (code == OPER_MULT) || (code == OPER_DIV);

endmodule

// File: rtl/alu_control_pipe.sv
// Registered ALU control at the ID/EX boundary: EX pipeline register plus a
// MULT/DIV occupancy sequencer that holds ID while a long op is in flight.
module alu_control_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W       = 3,
  parameter int FUNCT_W       = 6,
  parameter int OPER_W        = 4,
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = $clog2(MULDIV_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid_i,
  input  logic [ALUOP_W-1:0] alu_op_i,
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic               stall_i,
  input  logic               flush_i,
  output logic               ex_valid_o,
  output logic [OPER_W-1:0]  alu_operation_o,
  output logic               jr_o,
  output logic               illegal_o,
  output logic               muldiv_busy_o,
  output logic               muldiv_done_o,
  output logic               hold_o
);

  logic [OPER_W-1:0] dec_oper;
  logic              dec_jr;
  logic              dec_illegal;
  logic              dec_muldiv;
  logic              accept;
  muldiv_state_t     state;
  logic [CNT_W-1:0]  count;

  alu_decode #(
    .ALUOP_W (ALUOP_W),
    .FUNCT_W (FUNCT_W),
    .OPER_W  (OPER_W)
  ) u_decode (
    .alu_op    (alu_op_i),
    .funct     (funct_i),
    .oper      (dec_oper),
    .jr        (dec_jr),
    .illegal   (dec_illegal),
    .is_muldiv (dec_muldiv)
  );

  // muldiv_busy_o is a registered copy of (state == ST_BUSY).
  assign hold_o = muldiv_busy_o | stall_i;
  assign accept = id_valid_i & ~hold_o & ~stall_i & ~flush_i;

  // ID -> EX register: flush beats stall beats accept; otherwise a bubble.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      ex_valid_o      <= 1'b0;
      alu_operation_o <= '0;
      jr_o            <= 1'b0;
      illegal_o       <= 1'b0;
    end else if (stall_i) begin
      ex_valid_o      <= ex_valid_o;
    end else if (accept) begin
      ex_valid_o      <= 1'b1;
      alu_operation_o <= dec_oper;
      jr_o            <= dec_jr;
      illegal_o       <= dec_illegal;
    end else begin
      ex_valid_o      <= 1'b0;
      alu_operation_o <= '0;
      jr_o            <= 1'b0;
      illegal_o       <= 1'b0;
    end
  end

  // MULT/DIV sequencer: counts EX occupancy, pulses done, then releases ID.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      count         <= '0;
      muldiv_busy_o <= 1'b0;
      muldiv_done_o <= 1'b0;
    end else begin
      muldiv_done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept && dec_muldiv) begin
            state         <= ST_BUSY;
            count         <= CNT_W'(MULDIV_CYCLES - 1);
            muldiv_busy_o <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (flush_i) begin
            state         <= ST_IDLE;
            count         <= '0;
            muldiv_busy_o <= 1'b0;
          end else if (!stall_i) begin
            if (count == '0) begin
              state         <= ST_DONE;
              muldiv_busy_o <= 1'b0;
              muldiv_done_o <= 1'b1;
            end else begin
              count <= count - 1'b1;
            end
          end
        end
        ST_DONE: begin
          // A new MULT/DIV may be accepted in the done cycle itself.
          if (!flush_i && accept && dec_muldiv) begin
            state         <= ST_BUSY;
            count         <= CNT_W'(MULDIV_CYCLES - 1);
            muldiv_busy_o <= 1'b1;
          end else begin
            state <= ST_IDLE;
            count <= '0;
          end
        end
        default: begin
          state         <= ST_IDLE;
          count         <= '0;
          muldiv_busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_pipe.sv
// Self-checking bench for alu_control_pipe with a short MULT/DIV occupancy.
module tb_alu_control_pipe;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid_i;
  logic [2:0] alu_op_i;
  logic [5:0] funct_i;
  logic       stall_i;
  logic       flush_i;
  logic       ex_valid_o;
  logic [3:0] alu_operation_o;
  logic       jr_o;
  logic       illegal_o;
  logic       muldiv_busy_o;
  logic       muldiv_done_o;
  logic       hold_o;

  alu_control_pipe #(
    .ALUOP_W       (3),
    .FUNCT_W       (6),
    .OPER_W        (4),
    .MULDIV_CYCLES (C)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid_i      (id_valid_i),
    .alu_op_i        (alu_op_i),
    .funct_i         (funct_i),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .ex_valid_o      (ex_valid_o),
    .alu_operation_o (alu_operation_o),
    .jr_o            (jr_o),
    .illegal_o       (illegal_o),
    .muldiv_busy_o   (muldiv_busy_o),
    .muldiv_done_o   (muldiv_done_o),
    .hold_o          (hold_o)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // Reference model state: EX contents, remaining BUSY cycles, done pulse.
  bit       m_valid;
  bit [3:0] m_oper;
  bit       m_jr;
  bit       m_ill;
  int       m_left;
  bit       m_done;

  typedef struct {
    logic [2:0] op;
    logic [5:0] f;
    logic [3:0] oper;
    bit         jr;
    bit         ill;
  } vec_t;

  vec_t vt[17];

  int nb;
  int lat;
  int ndone;
  bit got;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Decode table from the instruction-set rules.
  function automatic bit [3:0] ref_decode(input logic [2:0] op, input logic [5:0] f);
    bit [3:0] o;
    o = 4'd9;
    if (op == 3'd7) begin
      case (f)
        6'd36: o = 4'd0;   // AND
        6'd37: o = 4'd1;   // OR
        6'd32: o = 4'd3;   // ADD
        6'd33: o = 4'd7;   // SUB
        6'd39: o = 4'd5;   // NOR
        6'd0:  o = 4'd4;   // SLL
        6'd2:  o = 4'd6;   // SRL
        6'd8:  o = 4'd8;   // JR
        6'd42: o = 4'd10;  // SLT
        6'd24: o = 4'd11;  // MULT
        6'd26: o = 4'd12;  // DIV
        default: o = 4'd9;
      endcase
    end else if (op == 3'd6 || op == 3'd2) o = 4'd3;
    else if (op == 3'd5) o = 4'd1;
    else if (op == 3'd3) o = 4'd0;
    else if (op == 3'd1) o = 4'd2;
    else if (op == 3'd4) o = 4'd7;
    return o;
  endfunction

  task automatic model_clear_ex();
    m_valid = 0; m_oper = 0; m_jr = 0; m_ill = 0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".ex_valid"}, ex_valid_o, m_valid);
    check({tag, ".oper"}, alu_operation_o, m_oper);
    check({tag, ".jr"}, jr_o, m_jr);
    check({tag, ".illegal"}, illegal_o, m_ill);
    check({tag, ".busy"}, muldiv_busy_o, (m_left > 0));
    check({tag, ".done"}, muldiv_done_o, m_done);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; id_valid_i = 0; alu_op_i = 0; funct_i = 0; stall_i = 0; flush_i = 0;
    @(posedge clk);
    model_clear_ex();
    m_left = 0; m_done = 0;
    #1 compare_all("reset");
    check("reset.hold", hold_o, 1'b0);
  endtask

  task automatic step(input bit v, input logic [2:0] op, input logic [5:0] f,
                      input bit st, input bit fl);
    bit       busy;
    bit       acc;
    bit [3:0] d;
    @(negedge clk);
    reset = 0; id_valid_i = v; alu_op_i = op; funct_i = f; stall_i = st; flush_i = fl;
    busy = (m_left > 0);
    #1 check("hold", hold_o, busy | st);
    @(posedge clk);
    acc = v && !(busy || st) && !fl;
    d   = ref_decode(op, f);
    if (fl) model_clear_ex();
    else if (st) begin end
    else if (acc) begin
      m_valid = 1; m_oper = d; m_jr = (d == 4'd8); m_ill = (d == 4'd9);
    end else model_clear_ex();
    if (fl && (busy || m_done)) begin
      m_left = 0; m_done = 0;
    end else if (busy) begin
      if (!st) begin
        m_left--;
        if (m_left == 0) m_done = 1;
      end
    end else begin
      m_done = 0;
      if (acc && (d == 4'd11 || d == 4'd12)) m_left = C;
    end
    #1 compare_all("step");
  endtask

  initial begin
    reset = 1; id_valid_i = 0; alu_op_i = 0; funct_i = 0; stall_i = 0; flush_i = 0;
    m_left = 0; m_done = 0;
    model_clear_ex();

    vt[0]  = '{3'b111, 6'b100000, 4'b0011, 0, 0};  // ADD
    vt[1]  = '{3'b111, 6'b100100, 4'b0000, 0, 0};  // AND
    vt[2]  = '{3'b111, 6'b100101, 4'b0001, 0, 0};  // OR
    vt[3]  = '{3'b111, 6'b100001, 4'b0111, 0, 0};  // SUB
    vt[4]  = '{3'b111, 6'b100111, 4'b0101, 0, 0};  // NOR
    vt[5]  = '{3'b111, 6'b000000, 4'b0100, 0, 0};  // SLL
    vt[6]  = '{3'b111, 6'b000010, 4'b0110, 0, 0};  // SRL
    vt[7]  = '{3'b111, 6'b001000, 4'b1000, 1, 0};  // JR
    vt[8]  = '{3'b111, 6'b101010, 4'b1010, 0, 0};  // SLT
    vt[9]  = '{3'b110, 6'b111111, 4'b0011, 0, 0};  // ADDI
    vt[10] = '{3'b101, 6'b000000, 4'b0001, 0, 0};  // ORI
    vt[11] = '{3'b011, 6'b100000, 4'b0000, 0, 0};  // ANDI
    vt[12] = '{3'b001, 6'b001000, 4'b0010, 0, 0};  // LUI
    vt[13] = '{3'b010, 6'b011000, 4'b0011, 0, 0};  // LW
    vt[14] = '{3'b100, 6'b101010, 4'b0111, 0, 0};  // BEQ, funct ignored
    vt[15] = '{3'b000, 6'b100000, 4'b1001, 0, 1};  // ALUOp 000
    vt[16] = '{3'b111, 6'b111111, 4'b1001, 0, 1};  // unknown R funct

    // Reset held for two cycles.
    do_reset();
    do_reset();

    // Decode table, one op per cycle.
    for (int i = 0; i < 17; i++) begin
      step(1, vt[i].op, vt[i].f, 0, 0);
      check($sformatf("tbl%0d.ex_valid", i), ex_valid_o, 1'b1);
      check($sformatf("tbl%0d.oper", i), alu_operation_o, vt[i].oper);
      check($sformatf("tbl%0d.jr", i), jr_o, vt[i].jr);
      check($sformatf("tbl%0d.illegal", i), illegal_o, vt[i].ill);
    end

    // MULT: busy/hold for C cycles, single done pulse, then ID accepted.
    step(1, 3'b111, 6'b011000, 0, 0);
    check("mult.ex_valid", ex_valid_o, 1'b1);
    nb = muldiv_busy_o ? 1 : 0; lat = 0; got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      step(1, 3'b111, 6'b100000, 0, 0);
      lat++;
      if (muldiv_busy_o) nb++;
      if (muldiv_done_o) got = 1;
      else check("mult.ex_bubble", ex_valid_o, 1'b0);
    end
    check("mult.busy_cycles", nb, C);
    check("mult.latency", lat, C);
    step(0, 3'b000, 6'b000000, 0, 0);
    check("mult.done_width", muldiv_done_o, 1'b0);
    step(1, 3'b111, 6'b100000, 0, 0);
    check("mult.after_accept", ex_valid_o, 1'b1);

    // DIV with a 3-cycle stall mid-BUSY: done arrives 3 cycles late.
    step(1, 3'b111, 6'b011010, 0, 0);
    check("div.oper", alu_operation_o, 4'b1100);
    step(0, 3'b000, 6'b000000, 0, 0);
    lat = 1;
    for (int k = 0; k < 3; k++) begin
      step(1, 3'b111, 6'b100000, 1, 0);
      lat++;
    end
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      step(0, 3'b000, 6'b000000, 0, 0);
      lat++;
      if (muldiv_done_o) got = 1;
    end
    check("div.stall_latency", lat, C + 3);

    // Back-to-back MULT issued in the done cycle.
    step(1, 3'b111, 6'b011000, 0, 0);
    for (int k = 0; k < C; k++) step(0, 3'b000, 6'b000000, 0, 0);
    check("b2b.done", muldiv_done_o, 1'b1);
    step(1, 3'b111, 6'b011000, 0, 0);
    check("b2b.rebusy", muldiv_busy_o, 1'b1);
    for (int k = 0; k < C + 1; k++) step(0, 3'b000, 6'b000000, 0, 0);

    // Flush together with stall on an accept cycle.
    step(1, 3'b111, 6'b100000, 0, 0);
    step(1, 3'b111, 6'b100001, 1, 1);
    check("flush_stall.ex_valid", ex_valid_o, 1'b0);
    check("flush_stall.oper", alu_operation_o, 4'b0000);

    // Flush mid-BUSY: IDLE next cycle and no done pulse.
    step(1, 3'b111, 6'b011000, 0, 0);
    step(0, 3'b000, 6'b000000, 0, 0);
    step(0, 3'b000, 6'b000000, 0, 1);
    check("flush_busy.busy", muldiv_busy_o, 1'b0);
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      step(0, 3'b000, 6'b000000, 0, 0);
      if (muldiv_done_o) ndone++;
    end
    check("flush_busy.no_done", ndone, 0);

    // Reset mid-BUSY: IDLE next cycle and no done pulse.
    step(1, 3'b111, 6'b011010, 0, 0);
    step(0, 3'b000, 6'b000000, 0, 0);
    do_reset();
    check("rst_busy.busy", muldiv_busy_o, 1'b0);
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      step(0, 3'b000, 6'b000000, 0, 0);
      if (muldiv_done_o) ndone++;
    end
    check("rst_busy.no_done", ndone, 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic [5:0] f;
      logic [5:0] pick [8];
      pick = '{6'd32, 6'd24, 6'd26, 6'd8, 6'd42, 6'd36, 6'd0, 6'd39};
      f = ($urandom_range(0, 1) == 0) ? pick[$urandom_range(0, 7)] : 6'($urandom);
      step(($urandom_range(0, 9) < 7), 3'($urandom), f,
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
